// File: rtl/player_sprite_fetch_pkg.sv
// Shared sprite geometry, ROM address width and animation state encoding
// for the player sprite fetch pipeline.
package player_sprite_fetch_pkg;

    localparam int SPRITE_W_DEF = 32;
    localparam int SPRITE_H_DEF = 48;
    localparam int FRAMES_DEF   = 4;
    localparam int ANIM_DIV_DEF = 8;
    localparam int ROM_AW       = 13;

    localparam logic [3:0] TRANSP_IDX_DEF = 4'h1;

    typedef enum logic {
        ANIM_IDLE,
        ANIM_WALK
    } anim_state_t;

    // Counter width helper that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/player_sprite_fetch_if.sv
// Sprite ROM bus: the fetch block drives the address, the synchronous ROM
// answers with a palette index one clock later.
interface player_sprite_fetch_if;
    import player_sprite_fetch_pkg::*;

    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);

endinterface

// File: rtl/player_sprite_fetch_anim_ctrl.sv
// Walk-cycle animation controller: IDLE/WALK state machine plus the video
// frame divider, stepped only on frame-start pulses.
module sprite_anim_ctrl
    import player_sprite_fetch_pkg::*;
#(
    parameter int FRAMES   = FRAMES_DEF,
    parameter int ANIM_DIV = ANIM_DIV_DEF,
    localparam int FW      = clog2_min1(FRAMES),
    localparam int DW      = clog2_min1(ANIM_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic          moving,
    output logic [FW-1:0] anim_frame
);

    anim_state_t   state_q;
    logic [DW-1:0] div_q;
    logic [FW-1:0] frame_q;
    logic          div_wrap;
    logic          frame_wrap;

    assign div_wrap   = (div_q == DW'(ANIM_DIV - 1));
    assign frame_wrap = (frame_q == FW'(FRAMES - 1));

    // The frame start that enters WALK already counts as the first divider tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ANIM_IDLE;
            div_q   <= '0;
            frame_q <= '0;
        end else if (frame_start) begin
            case (state_q)
                ANIM_IDLE: begin
                    if (moving) begin
                        state_q <= ANIM_WALK;
                        if (div_wrap) begin
                            div_q   <= '0;
                            frame_q <= frame_wrap ? '0 : frame_q + FW'(1);
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                end
                default: begin
                    if (!moving) begin
                        state_q <= ANIM_IDLE;
                        div_q   <= '0;
                        frame_q <= '0;
                    end else if (div_wrap) begin
                        div_q   <= '0;
                        frame_q <= frame_wrap ? '0 : frame_q + FW'(1);
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
            endcase
        end
    end

    assign anim_frame = frame_q;

endmodule

// File: rtl/player_sprite_fetch.sv
// Player sprite fetch: hit test and ROM addressing (stage 1), ROM latency
// alignment (stage 2), transparency keying (stage 3).
module player_sprite_fetch
    import player_sprite_fetch_pkg::*;
#(
    parameter int         SPRITE_W   = SPRITE_W_DEF,
    parameter int         SPRITE_H   = SPRITE_H_DEF,
    parameter int         FRAMES     = FRAMES_DEF,
    parameter int         ANIM_DIV   = ANIM_DIV_DEF,
    parameter logic [3:0] TRANSP_IDX = TRANSP_IDX_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] PlayerX,
    input  logic [9:0] PlayerY,
    input  logic       facing_left,
    input  logic       moving,
    output logic [3:0] pixel_index,
    output logic       pixel_on,
    player_sprite_fetch_if.master rom
);

    localparam int FW = clog2_min1(FRAMES);

    logic              vs_q, vs_d;
    logic              frame_start_q, frame_start_d;
    logic [9:0]        px_q, px_d;
    logic [9:0]        py_q, py_d;
    logic              facing_q, facing_d;
    logic              moving_q, moving_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              hit_d1_q, hit_d1_d;
    logic              hit_d2_q, hit_d2_d;
    logic [3:0]        pixel_index_q, pixel_index_d;
    logic              pixel_on_q, pixel_on_d;

    logic [FW-1:0]     anim_frame;
    logic [10:0]       x_ext, y_ext, x_lo, y_lo;
    logic              hit;
    logic [9:0]        lx, ly, lx_m;

    sprite_anim_ctrl #(
        .FRAMES   (FRAMES),
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk         (Clk),
        .reset_n     (Reset_n),
        .frame_start (frame_start_q),
        .moving      (moving_d),
        .anim_frame  (anim_frame)
    );

    // Position, facing and moving are only sampled on frame start so a frame is never torn.
    always_comb begin
        vs_d          = vs;
        frame_start_d = vs & ~vs_q;
        px_d          = frame_start_q ? PlayerX     : px_q;
        py_d          = frame_start_q ? PlayerY     : py_q;
        facing_d      = frame_start_q ? facing_left : facing_q;
        moving_d      = frame_start_q ? moving      : moving_q;
    end

    // Bounds are compared one bit wider so PlayerX near 1023 plus the width cannot wrap.
    always_comb begin
        x_ext = {1'b0, DrawX};
        y_ext = {1'b0, DrawY};
        x_lo  = {1'b0, px_q};
        y_lo  = {1'b0, py_q};
        hit   = (x_ext >= x_lo) && (x_ext < x_lo + 11'(SPRITE_W)) &&
                (y_ext >= y_lo) && (y_ext < y_lo + 11'(SPRITE_H));
        lx    = DrawX - px_q;
        ly    = DrawY - py_q;
        lx_m  = facing_q ? (10'(SPRITE_W - 1) - lx) : lx;

        rom_addr_d = '0;
        if (hit) begin
            rom_addr_d = ROM_AW'(anim_frame) * ROM_AW'(SPRITE_W * SPRITE_H) +
                         ROM_AW'(ly) * ROM_AW'(SPRITE_W) + ROM_AW'(lx_m);
        end
        hit_d1_d = hit;
        hit_d2_d = hit_d1_q;
    end

    // hit_d2 lines up with rom_data because the ROM adds exactly one cycle.
    always_comb begin
        pixel_index_d = '0;
        pixel_on_d    = 1'b0;
        if (hit_d2_q) begin
            pixel_index_d = rom.rom_data;
            pixel_on_d    = (rom.rom_data != TRANSP_IDX);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            px_q          <= '0;
            py_q          <= '0;
            facing_q      <= 1'b0;
            moving_q      <= 1'b0;
            rom_addr_q    <= '0;
            hit_d1_q      <= 1'b0;
            hit_d2_q      <= 1'b0;
            pixel_index_q <= '0;
            pixel_on_q    <= 1'b0;
        end else begin
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            px_q          <= px_d;
            py_q          <= py_d;
            facing_q      <= facing_d;
            moving_q      <= moving_d;
            rom_addr_q    <= rom_addr_d;
            hit_d1_q      <= hit_d1_d;
            hit_d2_q      <= hit_d2_d;
            pixel_index_q <= pixel_index_d;
            pixel_on_q    <= pixel_on_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign pixel_index  = pixel_index_q;
    assign pixel_on     = pixel_on_q;

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Scoreboard bench for player_sprite_fetch: directed pixels push expected
// rom_addr and pixel results; a negedge monitor pops and compares them.
module tb_player_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       vs;
    logic [9:0] DrawX, DrawY, PlayerX, PlayerY;
    logic       facing_left, moving;
    logic [3:0] pixel_index;
    logic       pixel_on;

    player_sprite_fetch_if rif();

    player_sprite_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .vs          (vs),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .PlayerX     (PlayerX),
        .PlayerY     (PlayerY),
        .facing_left (facing_left),
        .moving      (moving),
        .pixel_index (pixel_index),
        .pixel_on    (pixel_on),
        .rom         (rif)
    );

    always #5 Clk = ~Clk;

    // ROM model: palette index is the low nibble of the address, one-cycle read.
    always @(posedge Clk) rif.rom_data <= rif.rom_addr[3:0];

    typedef struct {
        int          due;
        logic [12:0] addr;
        string       name;
    } addr_exp_t;

    typedef struct {
        int          due;
        logic [3:0]  idx;
        logic        on;
        string       name;
    } pix_exp_t;

    addr_exp_t addr_q[$];
    pix_exp_t  pix_q[$];
    addr_exp_t ea;
    pix_exp_t  ep;
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            ea = addr_q.pop_front();
            checks++;
            if (ea.due != cyc || rif.rom_addr !== ea.addr) begin
                errors++;
                $display("[TB] FAIL %s rom_addr got %0d expected %0d (cycle %0d due %0d)",
                         ea.name, rif.rom_addr, ea.addr, cyc, ea.due);
            end
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            ep = pix_q.pop_front();
            checks++;
            if (ep.due != cyc || pixel_index !== ep.idx || pixel_on !== ep.on) begin
                errors++;
                $display("[TB] FAIL %s pixel got idx=%0d on=%0d expected idx=%0d on=%0d",
                         ep.name, pixel_index, pixel_on, ep.idx, ep.on);
            end
        end
    end

    // Drive one pixel; the expected address appears 1 cycle later, the pixel 3 cycles later.
    task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y,
                                  input bit hit, input logic [12:0] a, input string nm);
        logic [3:0] idx;
        DrawX = x;
        DrawY = y;
        idx   = hit ? a[3:0] : 4'd0;
        addr_q.push_back('{due: cyc + 1, addr: (hit ? a : 13'd0), name: nm});
        pix_q.push_back('{due: cyc + 3, idx: idx, on: (hit && idx != 4'h1), name: nm});
        @(negedge Clk);
    endtask

    task automatic expect_reset(input string nm);
        addr_q.push_back('{due: cyc + 1, addr: 13'd0, name: nm});
        pix_q.push_back('{due: cyc + 1, idx: 4'd0, on: 1'b0, name: nm});
    endtask

    task automatic idle(input int n);
        DrawX = 10'd700;
        DrawY = 10'd700;
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_frame();
        DrawX = 10'd700;
        DrawY = 10'd700;
        vs = 1'b0;
        @(negedge Clk);
        vs = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        vs = 1'b1;
        DrawX = 10'd700;
        DrawY = 10'd700;
        PlayerX = '0;
        PlayerY = '0;
        facing_left = 1'b0;
        moving = 1'b0;
        @(negedge Clk);
        expect_reset("reset_initial");
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);

        PlayerX = 10'd100;
        PlayerY = 10'd200;
        do_frame();
        apply_stimulus(10'd100, 10'd200, 1, 13'd0,    "top_left");
        apply_stimulus(10'd101, 10'd200, 1, 13'd1,    "transparent");
        apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "opaque_3");
        apply_stimulus(10'd131, 10'd247, 1, 13'd1535, "bottom_right");
        apply_stimulus(10'd132, 10'd200, 0, 13'd0,    "right_edge_excl");
        apply_stimulus(10'd100, 10'd248, 0, 13'd0,    "bottom_edge_excl");
        apply_stimulus(10'd99,  10'd200, 0, 13'd0,    "left_outside");

        facing_left = 1'b1;
        do_frame();
        apply_stimulus(10'd100, 10'd201, 1, 13'd63,   "mirror_row1");
        apply_stimulus(10'd131, 10'd200, 1, 13'd0,    "mirror_right");
        apply_stimulus(10'd132, 10'd201, 0, 13'd0,    "mirror_edge_excl");

        PlayerX = 10'd300;
        idle(2);
        apply_stimulus(10'd100, 10'd201, 1, 13'd63,   "midframe_hold");
        apply_stimulus(10'd300, 10'd201, 0, 13'd0,    "midframe_newpos");
        do_frame();
        apply_stimulus(10'd300, 10'd201, 1, 13'd63,   "newframe_pos");
        apply_stimulus(10'd100, 10'd201, 0, 13'd0,    "newframe_oldpos");

        PlayerX = 10'd1000;
        facing_left = 1'b0;
        do_frame();
        apply_stimulus(10'd5,    10'd200, 0, 13'd0,   "no_wrap");
        apply_stimulus(10'd1000, 10'd200, 1, 13'd0,   "far_right_hit");
        apply_stimulus(10'd1023, 10'd200, 1, 13'd23,  "far_right_edge");

        PlayerX = 10'd100;
        moving = 1'b1;
        for (int f = 1; f <= 40; f++) begin
            do_frame();
            case (f)
                1:  apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "walk_f1");
                7:  apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "walk_f7");
                8:  apply_stimulus(10'd103, 10'd200, 1, 13'd1539, "walk_f8");
                15: apply_stimulus(10'd103, 10'd200, 1, 13'd1539, "walk_f15");
                16: apply_stimulus(10'd103, 10'd200, 1, 13'd3075, "walk_f16");
                24: apply_stimulus(10'd103, 10'd200, 1, 13'd4611, "walk_f24");
                31: apply_stimulus(10'd103, 10'd200, 1, 13'd4611, "walk_f31");
                32: apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "walk_wrap");
                40: apply_stimulus(10'd103, 10'd200, 1, 13'd1539, "walk_f40");
                default: ;
            endcase
        end

        moving = 1'b0;
        do_frame();
        apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "stop_idle");
        moving = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            do_frame();
            if (f == 7) apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "restart_f7");
            if (f == 8) apply_stimulus(10'd103, 10'd200, 1, 13'd1539, "restart_f8");
        end

        idle(4);
        DrawX = 10'd103;
        DrawY = 10'd200;
        @(negedge Clk);
        Reset_n = 1'b0;
        expect_reset("reset_midstream");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        moving = 1'b0;
        idle(3);
        apply_stimulus(10'd103, 10'd200, 0, 13'd0,    "post_reset_pos0");
        do_frame();
        apply_stimulus(10'd103, 10'd200, 1, 13'd3,    "post_reset_frame");

        for (int i = 0; i < 20 && (addr_q.size() > 0 || pix_q.size() > 0); i++)
            idle(1);
        if (addr_q.size() > 0 || pix_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending addr=%0d pix=%0d expected 0",
                     addr_q.size(), pix_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_sprite_fetch.md
PLAYER_SPRITE_FETCH -- requirements
Module: player_sprite_fetch

Interface
REQ-001 Parameter SPRITE_W, default 32: sprite width in pixels.
REQ-002 Parameter SPRITE_H, default 48: sprite height in pixels.
REQ-003 Parameter FRAMES, default 4: animation frames stored back-to-back in the sprite ROM.
REQ-004 Parameter ANIM_DIV, default 8: video frames per animation step.
REQ-005 Parameter TRANSP_IDX, default 4'h1: palette index treated as transparent (magenta key).
REQ-006 Clk  in  1  pixel clock; the only clock.
REQ-007 Reset_n  in  1  reset, synchronous, active-low.
REQ-008 vs  in  1  VGA vertical sync, active-low.
REQ-009 DrawX  in  10  current pixel column.
REQ-010 DrawY  in  10  current pixel row.
REQ-011 PlayerX  in  10  sprite top-left column.
REQ-012 PlayerY  in  10  sprite top-left row.
REQ-013 facing_left  in  1  1 = draw horizontally mirrored.
REQ-014 moving  in  1  1 = animate walk cycle.
REQ-015 rom_addr  out  13  address to external synchronous sprite ROM, 1-cycle read latency.
REQ-016 rom_data  in  4  palette index returned by ROM.
REQ-017 pixel_index  out  4  palette index for downstream palette lookup.
REQ-018 pixel_on  out  1  1 = sprite pixel is opaque at the aligned position.

Function
REQ-019 Frame start SHALL be a one-cycle internal pulse on the cycle after vs is sampled 1 following a sample of 0 (rising edge, registered detector).
REQ-020 On frame start, PlayerX, PlayerY, facing_left and moving SHALL be latched; all address math uses only latched values, so a frame is never torn.
REQ-021 Hit condition SHALL be DrawX >= PX and DrawX < PX+SPRITE_W, and likewise for Y/SPRITE_H, evaluated at 11-bit width so PX+SPRITE_W never wraps.
REQ-022 Local coordinates: lx = DrawX-PX, ly = DrawY-PY; if latched facing is left, lx' = SPRITE_W-1-lx, else lx' = lx.
REQ-023 rom_addr SHALL equal anim_frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx', registered (stage 1); when not hit, rom_addr SHALL hold 0.
REQ-024 The hit flag SHALL be delayed in step with the ROM so it aligns with rom_data (stage 2).
REQ-025 Stage 3 registers pixel_index = rom_data and pixel_on = hit_d2 AND (rom_data != TRANSP_IDX); when hit_d2 is 0, pixel_index = 0 and pixel_on = 0.
REQ-026 Total latency SHALL be exactly 3 Clk cycles from DrawX/DrawY to pixel_index/pixel_on; the pipeline advances every cycle with no stalls.
REQ-027 Animation state machine: IDLE (anim_frame=0, div_cnt=0) and WALK; transitions are evaluated only on frame start.
REQ-028 IDLE -> WALK when latched moving=1; WALK -> IDLE when latched moving=0, forcing anim_frame=0 and div_cnt=0.
REQ-029 In WALK, div_cnt increments each frame start; at ANIM_DIV-1 it wraps to 0 and anim_frame advances, wrapping FRAMES-1 -> 0.
REQ-030 If frame start and a mid-frame change of moving coincide, only the value latched at that frame start counts.

Reset
REQ-031 While Reset_n=0 at a Clk edge: rom_addr=0, pixel_index=0, pixel_on=0, all pipeline flags 0, state=IDLE, anim_frame=0, div_cnt=0, latched position/facing/moving=0, vs history=1.
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge; the first frame start after release uses freshly latched inputs.

Structure
REQ-033 A shared package SHALL hold the sprite geometry constants, the ROM address width, and the animation state enum.
REQ-034 The animation state machine plus divider SHALL be one sub-module, sprite_anim_ctrl; address/pipeline logic stays in the top module.

Verification
REQ-035 PlayerX=100, PlayerY=200, facing=0, DrawX=100, DrawY=200 -> rom_addr=0 after 1 cycle; pixel_index=rom_data 3 cycles after input.
REQ-036 Same position, facing=1, DrawX=100, DrawY=201 -> rom_addr=63 (31+32); DrawX=132 -> pixel_on=0 (right edge exclusive).
REQ-037 moving=1 held for 16 frame starts -> anim_frame steps 0->1 at frame 8, ->2 at frame 16; rom_addr base 1536 then 3072.
REQ-038 moving=1 for 32 frame starts -> anim_frame wraps 3->0; then moving=0 -> anim_frame=0, state IDLE at the next frame start.
REQ-039 rom_data=4'h1 inside the box -> pixel_on=0; rom_data=4'h3 -> pixel_on=1, pixel_index=3.
REQ-040 PlayerX=1000, DrawX=5 -> no false hit (no wrap); change PlayerX mid-frame -> rom_addr unaffected until next frame start; Reset_n=0 mid-stream -> all outputs 0 next cycle.
